uart_rx_param: RTL and testbench

- Parametrised UART serial receiver; successor to the fixed 8N1 receiver.
- Configurable data width, optional parity (even/odd) and 1 or 2 stop bits.
- Reports parity and framing errors; recovers cleanly after a break or low line.
- Sits between the board Rx pin and the UART byte consumer (FIFO or command decoder) in the same single clock domain.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_rx_param.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and constants for the parametrised UART receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 40;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module : uart_sync2
// Brief  : Two-flop synchroniser for an idle-high asynchronous input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// Module : uart_rx_param
// Brief  : Parametrised UART receiver (5..9 data bits, optional parity,
//          1 or 2 stop bits) with parity/framing error reporting.
//          Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  output logic                 Rx_done_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_idx_w = $clog2(DATA_BITS);

  localparam logic [c_cnt_w-1:0] c_cnt_half  = c_cnt_w'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_BITS - 1);
  localparam logic               c_stop_last = 1'(STOP_BITS - 1);
  localparam logic               c_par_mode  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  localparam logic [2:0] c_st_idle   = IDLE;
  localparam logic [2:0] c_st_start  = START;
  localparam logic [2:0] c_st_data   = DATA;
  localparam logic [2:0] c_st_parity = PARITY;
  localparam logic [2:0] c_st_stop   = STOP;
  localparam logic [2:0] c_st_break  = BREAK_WAIT;

  logic                 w_rx;
  logic                 w_sample_now;
  logic                 w_bit;
  logic                 w_sampling;
  logic [2:0]           r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par_pend;
  logic                 r_frame_pend;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (Rx),
    .q     (w_rx)
  );

  assign w_sampling = (r_state == c_st_data) || (r_state == c_st_parity) ||
                      (r_state == c_st_stop);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [c_cnt_w-1:0] c_cnt_prev = c_cnt_w'(CLKS_PER_BIT - 2);

  logic r_maj_a;
  logic r_maj_b;
  logic r_vote_pend;

  // Third vote is the live sample one cycle after the nominal centre.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_maj_a     <= 1'b1;
      r_maj_b     <= 1'b1;
      r_vote_pend <= 1'b0;
    end else begin
      if (r_cnt == c_cnt_prev) r_maj_a <= w_rx;
      if (r_cnt == c_cnt_last) r_maj_b <= w_rx;
      r_vote_pend <= w_sampling && (r_cnt == c_cnt_last) && !r_vote_pend;
    end
  end

  assign w_sample_now = r_vote_pend;
  assign w_bit        = maj3(r_maj_a, r_maj_b, w_rx);
`else
  assign w_sample_now = (r_cnt == c_cnt_last);
  assign w_bit        = w_rx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_stop_idx   <= 1'b0;
      r_shreg      <= '0;
      r_par_pend   <= 1'b0;
      r_frame_pend <= 1'b0;
      Rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      Rx_done_tick <= 1'b0;
      case (r_state)
        c_st_idle: begin
          r_cnt      <= '0;
          r_idx      <= '0;
          r_stop_idx <= 1'b0;
          if (!w_rx) r_state <= c_st_start;
        end
        c_st_start: begin
          if (r_cnt == c_cnt_half) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_state      <= c_st_data;
              r_shreg      <= '0;
              r_idx        <= '0;
              r_par_pend   <= 1'b0;
              r_frame_pend <= 1'b0;
            end else begin
              r_state <= c_st_idle;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_st_data: begin
          if (w_sample_now) begin
            r_cnt          <= '0;
            r_shreg[r_idx] <= w_bit;
            if (r_idx == c_idx_last) begin
              r_idx      <= '0;
              r_stop_idx <= 1'b0;
              r_state    <= (PARITY_EN != 0) ? c_st_parity : c_st_stop;
            end else begin
              r_idx <= r_idx + c_idx_w'(1);
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_st_parity: begin
          if (w_sample_now) begin
            r_cnt      <= '0;
            r_par_pend <= w_bit ^ (^r_shreg) ^ c_par_mode;
            r_state    <= c_st_stop;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_st_stop: begin
          if (w_sample_now) begin
            r_cnt <= '0;
            if (r_stop_idx == c_stop_last) begin
              Rx_done_tick <= 1'b1;
              dout         <= r_shreg;
              parity_err   <= (PARITY_EN != 0) ? r_par_pend : 1'b0;
              frame_err    <= r_frame_pend | ~w_bit;
              // A low stop bit usually means a break; wait for the line to idle.
              r_state      <= (r_frame_pend | ~w_bit) ? c_st_break : c_st_idle;
            end else begin
              r_stop_idx   <= r_stop_idx + 1'b1;
              r_frame_pend <= r_frame_pend | ~w_bit;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_st_break: begin
          r_cnt <= '0;
          if (w_rx) r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ============================================================================
// Module : tb_uart_rx_param
// Brief  : Directed self-checking bench: 8N1, 7E1 and 8N2 receivers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 40;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a  = 1'b1;
  logic       rx_b  = 1'b1;
  logic       rx_c  = 1'b1;
  logic       tick_a, tick_b, tick_c;
  logic [7:0] dout_a, dout_c;
  logic [6:0] dout_b;
  logic       perr_a, perr_b, perr_c;
  logic       ferr_a, ferr_b, ferr_c;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .Rx(rx_a), .Rx_done_tick(tick_a),
    .dout(dout_a), .parity_err(perr_a), .frame_err(ferr_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1),
                  .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .Rx(rx_b), .Rx_done_tick(tick_b),
    .dout(dout_b), .parity_err(perr_b), .frame_err(ferr_b));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .Rx(rx_c), .Rx_done_tick(tick_c),
    .dout(dout_c), .parity_err(perr_c), .frame_err(ferr_c));

  int cyc = 0;
  int ticks_a = 0, ticks_b = 0, ticks_c = 0;
  int tcyc_a = 0, tcyc_b = 0, tcyc_c = 0;
  int errors = 0, checks = 0;
  int c0;

  // tcyc_* holds the index of the clock edge that raised the tick.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tick_a) begin ticks_a <= ticks_a + 1; tcyc_a <= cyc; end
    if (tick_b) begin ticks_b <= ticks_b + 1; tcyc_b <= cyc; end
    if (tick_c) begin ticks_c <= ticks_c + 1; tcyc_c <= cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the line falling to the tick: 1 to first edge, 2 sync, half bit, bits, 1.
  function automatic int lat(input int nbits);
    return 1 + 2 + (CPB - 1) / 2 + nbits * (CPB + MAJ) + 1;
  endfunction

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input logic last_lvl);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      repeat (CPB) @(negedge clk);
    end
    set_rx(sel, last_lvl);
  endtask

  task automatic send_maj(input logic [9:0] bits);
    for (int t = 0; t < 10 * CPB; t++) begin
      logic lvl;
      lvl = bits[t / CPB];
      for (int k = 1; k <= 9; k++)
        if (t == 19 + 41 * k) lvl = ~lvl;
      rx_a = lvl;
      @(negedge clk);
    end
    rx_a = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dout_a", dout_a, 8'h00);
    check("rst_tick_a", tick_a, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_state_a", dut_a.r_state, IDLE);
    check("idle_flags_a", {perr_a, ferr_a}, 2'b00);
    check("idle_dout_b", dout_b, 7'h00);

    // 8N1 0xA5
    c0 = cyc;
    send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b1);
    repeat (5) @(negedge clk);
    check("a5_ticks", ticks_a, 1);
    check("a5_dout", dout_a, 8'hA5);
    check("a5_flags", {perr_a, ferr_a}, 2'b00);
    check("a5_latency", tcyc_a, c0 + lat(9));

    // 7E1 with correct and wrong parity
    c0 = cyc;
    send_bits(1, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 1'b1);
    repeat (5) @(negedge clk);
    check("p41_ticks", ticks_b, 1);
    check("p41_dout", dout_b, 7'h41);
    check("p41_perr", perr_b, 1'b0);
    check("p41_latency", tcyc_b, c0 + lat(9));
    send_bits(1, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 10, 1'b1);
    repeat (5) @(negedge clk);
    check("p41bad_ticks", ticks_b, 2);
    check("p41bad_dout", dout_b, 7'h41);
    check("p41bad_perr", perr_b, 1'b1);
    check("p41bad_ferr", ferr_b, 1'b0);
    send_bits(1, 16'({1'b1, 1'b1, 7'h07, 1'b0}), 10, 1'b1);
    repeat (5) @(negedge clk);
    check("p07_dout", dout_b, 7'h07);
    check("p07_perr", perr_b, 1'b0);

    // 8N2, second stop low, then a held-low line
    c0 = cyc;
    send_bits(2, 16'({1'b0, 1'b1, 8'hC3, 1'b0}), 11, 1'b0);
    check("brk_ticks", ticks_c, 1);
    check("brk_dout", dout_c, 8'hC3);
    check("brk_ferr", ferr_c, 1'b1);
    check("brk_latency", tcyc_c, c0 + lat(10));
    check("brk_state", dut_c.r_state, BREAK_WAIT);
    repeat (5 * CPB) @(negedge clk);
    check("brk_hold_ticks", ticks_c, 1);
    check("brk_hold_state", dut_c.r_state, BREAK_WAIT);
    rx_c = 1'b1;
    repeat (CPB) @(negedge clk);
    check("brk_release_state", dut_c.r_state, IDLE);
    send_bits(2, 16'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, 1'b1);
    repeat (5) @(negedge clk);
    check("s3c_ticks", ticks_c, 2);
    check("s3c_dout", dout_c, 8'h3C);
    check("s3c_ferr", ferr_c, 1'b0);

    // 10-cycle glitch on an idle line
    rx_a = 1'b0;
    repeat (10) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_ticks", ticks_a, 1);
    check("glitch_dout", dout_a, 8'hA5);
    check("glitch_state", dut_a.r_state, IDLE);

    // Reset in the middle of data bit 4 of 0xFF
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("abort_in_data", dut_a.r_state, DATA);
    reset = 1'b1;
    #1;
    check("abort_dout", dout_a, 8'h00);
    check("abort_tick", tick_a, 1'b0);
    check("abort_state", dut_a.r_state, IDLE);
    check("abort_dout_c", dout_c, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6 * CPB) @(negedge clk);
    check("abort_no_tick", ticks_a, 1);
    send_bits(0, 16'({1'b1, 8'h12, 1'b0}), 10, 1'b1);
    repeat (5) @(negedge clk);
    check("r12_ticks", ticks_a, 2);
    check("r12_dout", dout_a, 8'h12);
    check("r12_flags", {perr_a, ferr_a}, 2'b00);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted pulse on the centre vote of every sampled bit
    send_maj(10'({1'b1, 8'h5A, 1'b0}));
    repeat (5) @(negedge clk);
    check("maj_ticks", ticks_a, 3);
    check("maj_dout", dout_a, 8'h5A);
    check("maj_flags", {perr_a, ferr_a}, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
